spi_reg_bank: RTL and testbench

Parametrised SPI mode-0 register-bank peripheral: a 2-FF synchronised, oversampled serial slave that writes and (optionally) reads back a bank of `NUM_REGS` configuration registers. It sits between the chip's SPI pins and the output-enable and PWM control logic, and generalises the fixed 5×8-bit write-only register front end. Register contents leave the block as a flat bus.

---
 rtl/spi_reg_pkg.sv | 21 ++
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_reg_bank.sv | 152 +++++++++++++++
 tb/tb_spi_reg_bank.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared types, frame sizing and register map for the SPI register bank
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } state_e;

  localparam int EN_OUT_LO = 0;
  localparam int EN_OUT_HI = 1;
  localparam int EN_PWM_LO = 2;
  localparam int EN_PWM_HI = 3;
  localparam int PWM_DUTY  = 4;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage synchroniser with registered-level edge detect
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - oversampled SPI mode-0 slave writing a flat register bank
// Define SPI_READBACK_EN to build the cipo read path; otherwise the bank is write-only.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk_i,
  input  logic                       ncs_i,
  input  logic                       copi_i,
  output logic                       cipo_o,
  output logic                       cipo_oe_o,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]        wr_strobe_o,
  output logic                       frame_err_o
);

  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int SR_W      = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic copi_lvl, copi_rise_unused, copi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(sclk_i),
    .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d_i(ncs_i),
    .level_o(ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d_i(copi_i),
    .level_o(copi_lvl), .rise_o(copi_rise_unused), .fall_o(copi_fall_unused)
  );

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [SR_W-2:0]            sr_q, sr_d;
  logic [SR_W-1:0]            sr_full;
  logic                       rw_q, rw_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]        wr_strobe_q, wr_strobe_d;
  logic                       frame_err_q, frame_err_d;
  logic                       enter_data;

  // Shift register plus the bit being sampled now; the top bit never needs storing.
  assign sr_full = {sr_q, copi_lvl};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      regs_q      <= '0;
      wr_strobe_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    regs_d      = regs_q;
    wr_strobe_d = '0;
    frame_err_d = 1'b0;
    enter_data  = 1'b0;
    // ncs release wins over a coincident sclk edge, so a short frame aborts.
    if (ncs_rise) begin
      if (state_q == CMD || state_q == DATA) frame_err_d = 1'b1;
      state_d = IDLE;
    end else if (ncs_fall && state_q == IDLE) begin
      state_d = CMD;
      cnt_d   = '0;
    end else if (!ncs_lvl && sclk_rise && (state_q == CMD || state_q == DATA)) begin
      sr_d  = sr_full[SR_W-2:0];
      cnt_d = cnt_q + 1'b1;
      if (state_q == CMD && cnt_q == CNT_W'(ADDR_W)) begin
        rw_d       = sr_full[ADDR_W];
        addr_d     = sr_full[ADDR_W-1:0];
        state_d    = DATA;
        enter_data = 1'b1;
      end else if (state_q == DATA && cnt_q == CNT_W'(FRAME_LEN - 1)) begin
        state_d = DONE;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (rw_q && 32'(addr_q) == i) begin
            regs_d[i*DATA_W +: DATA_W] = sr_full[DATA_W-1:0];
            wr_strobe_d[i]             = 1'b1;
          end
        end
      end
    end
  end

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] sout_q, sout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sout_q <= '0;
    else        sout_q <= sout_d;
  end

  // The falling edge right after the load is skipped so the MSB meets the first data rise.
  always_comb begin
    sout_d = sout_q;
    if (enter_data) begin
      sout_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (32'(sr_full[ADDR_W-1:0]) == i) sout_d = regs_q[i*DATA_W +: DATA_W];
      end
    end else if (sclk_fall && state_q == DATA && cnt_q > CNT_W'(ADDR_W + 1)) begin
      sout_d = {sout_q[DATA_W-2:0], 1'b0};
    end
  end

  assign cipo_oe_o = ~ncs_lvl;
  assign cipo_o    = ~ncs_lvl & sout_q[DATA_W-1];
`else
  logic sclk_fall_unused, enter_data_unused;
  assign sclk_fall_unused  = sclk_fall;
  assign enter_data_unused = enter_data;
  assign cipo_oe_o         = 1'b0;
  assign cipo_o            = 1'b0;
`endif

  assign regs_o      = regs_q;
  assign wr_strobe_o = wr_strobe_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - directed self-checking bench for spi_reg_bank
module tb_spi_reg_bank;

`ifdef SPI_READBACK_EN
  localparam logic RB = 1'b1;
`else
  localparam logic RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk, ncs, copi;
  logic        cipo, cipo_oe;
  logic [39:0] regs;
  logic [4:0]  wr_strobe;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int strobe_cnt [5];
  int strobe_base[5];
  int strobe_wide = 0;
  int err_cnt = 0, err_base = 0, err_wide = 0;
  logic [4:0] strobe_prev = '0;
  logic       err_prev = 1'b0;

  always #5 clk = ~clk;

  spi_reg_bank dut (
    .clk(clk), .rst_n(rst_n), .sclk_i(sclk), .ncs_i(ncs), .copi_i(copi),
    .cipo_o(cipo), .cipo_oe_o(cipo_oe), .regs_o(regs),
    .wr_strobe_o(wr_strobe), .frame_err_o(frame_err)
  );

  initial for (int i = 0; i < 5; i++) strobe_cnt[i] = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) strobe_cnt[i] += int'(wr_strobe[i]);
    if (|wr_strobe && |strobe_prev) strobe_wide++;
    strobe_prev = wr_strobe;
    err_cnt += int'(frame_err);
    if (frame_err && err_prev) err_wide++;
    err_prev = frame_err;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < 5; i++) strobe_base[i] = strobe_cnt[i];
    err_base = err_cnt;
  endtask

  function automatic logic [4:0] strobe_delta();
    logic [4:0] d;
    for (int i = 0; i < 5; i++) d[i] = ((strobe_cnt[i] - strobe_base[i]) == 1);
    return d;
  endfunction

  function automatic int strobe_total();
    int t = 0;
    for (int i = 0; i < 5; i++) t += strobe_cnt[i] - strobe_base[i];
    return t;
  endfunction

  task automatic spi_bit(input logic b, output logic s, output logic o);
    @(negedge clk);
    sclk = 1'b0;
    copi = b;
    repeat (5) @(negedge clk);
    s = cipo;
    o = cipo_oe;
    sclk = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [31:0] word, input int nbits, input int gap,
                          output logic [31:0] cap, output logic oe_all);
    logic s, o;
    cap = '0;
    oe_all = 1'b1;
    @(negedge clk);
    ncs = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_bit(word[i], s, o);
      cap = {cap[30:0], s};
      oe_all = oe_all & o;
    end
    @(negedge clk);
    sclk = 1'b0;
    repeat (6) @(negedge clk);
    ncs = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  logic [31:0] cap;
  logic        oe_all, s_d, o_d;

  initial begin
    rst_n = 1'b0;
    ncs   = 1'b1;
    sclk  = 1'b0;
    copi  = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_regs", 64'(regs), 64'h0);
    check("reset_strobe", 64'(wr_strobe), 64'h0);
    check("reset_err", 64'(frame_err), 64'h0);
    check("reset_cipo", 64'(cipo), 64'h0);
    check("reset_oe", 64'(cipo_oe), 64'h0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    snap();
    spi_xfer(32'h84AA, 16, 10, cap, oe_all);
    check("wr4_regs", 64'(regs), 64'hAA_0000_0000);
    check("wr4_strobe", 64'(strobe_delta()), 64'h10);
    check("wr4_strobe_total", 64'(strobe_total()), 64'd1);
    check("wr4_err", 64'(err_cnt - err_base), 64'd0);

    spi_xfer(32'h813C, 16, 10, cap, oe_all);
    check("wr1_regs", 64'(regs), 64'hAA_0000_3C00);
    snap();
    spi_xfer(32'h0100, 16, 10, cap, oe_all);
    check("rd1_data", 64'(cap[7:0]), RB ? 64'h3C : 64'h00);
    check("rd1_oe_during", 64'(oe_all), 64'(RB));
    check("rd1_oe_after", 64'(cipo_oe), 64'h0);
    check("rd1_no_strobe", 64'(strobe_total()), 64'd0);
    check("rd1_no_err", 64'(err_cnt - err_base), 64'd0);
    check("rd1_regs", 64'(regs), 64'hAA_0000_3C00);

    snap();
    spi_xfer(32'h85FF, 16, 10, cap, oe_all);
    check("wr5_regs", 64'(regs), 64'hAA_0000_3C00);
    check("wr5_no_strobe", 64'(strobe_total()), 64'd0);
    spi_xfer(32'h0500, 16, 10, cap, oe_all);
    check("rd5_data", 64'(cap[7:0]), 64'h00);
    check("rd5_oe_during", 64'(oe_all), 64'(RB));

    snap();
    spi_xfer(32'h8277 >> 6, 10, 10, cap, oe_all);
    check("abort_err", 64'(err_cnt - err_base), 64'd1);
    check("abort_regs", 64'(regs), 64'hAA_0000_3C00);
    check("abort_no_strobe", 64'(strobe_total()), 64'd0);

    @(negedge clk);
    ncs = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, s_d, o_d);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_regs", 64'(regs), 64'h0);
    check("midrst_strobe", 64'(wr_strobe), 64'h0);
    check("midrst_err", 64'(frame_err), 64'h0);
    check("midrst_cipo", 64'(cipo), 64'h0);
    check("midrst_oe", 64'(cipo_oe), 64'h0);
    ncs  = 1'b1;
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    snap();
    spi_xfer(32'h8055, 16, 10, cap, oe_all);
    check("postrst_regs", 64'(regs), 64'h00_0000_0055);
    check("postrst_strobe", 64'(strobe_delta()), 64'h01);
    check("postrst_no_err", 64'(err_cnt - err_base), 64'd0);

    snap();
    spi_xfer(32'h8212, 16, 4, cap, oe_all);
    spi_xfer(32'h8334F, 20, 10, cap, oe_all);
    check("b2b_regs", 64'(regs), 64'h00_3412_0055);
    check("b2b_strobe", 64'(strobe_delta()), 64'h0C);
    check("b2b_strobe_total", 64'(strobe_total()), 64'd2);
    check("b2b_no_err", 64'(err_cnt - err_base), 64'd0);

    check("strobe_width", 64'(strobe_wide), 64'd0);
    check("err_width", 64'(err_wide), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
